ofs_plat_log_record_arb: RTL
============================

# ofs_plat_log_record_arb

Shares one platform trace/log record channel among N_REQ monitor requesters. Each requester presents tagged log records: class (NONE, HOST_CHAN, LOCAL_MEM, HSSI), instance number and payload. The block filters records by a per-class enable mask, arbitrates round-robin among the surviving requests, and timestamps each granted record. It emits one record per cycle through a registered valid/ready output toward the log sink.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..16)
- DATA_W, 64, record payload width
- INST_W, 4, instance (port/bank/chan) number width
- TS_W, 48, timestamp width
- DROP_W, 32, dropped-record counter width

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- class_en  in  4  per-class enable; bit g enables class g; bit 0 (NONE) is ignored and treated as 0
- req_valid  in  N_REQ  record valid per requester
- req_ready  out  N_REQ  record accepted (combinational)
- req_class  in  N_REQ*2  class code per requester
- req_inst  in  N_REQ*INST_W  instance number per requester
- req_data  in  N_REQ*DATA_W  payload per requester
- out_valid  out  1  registered record valid
- out_ready  in  1  sink accepts
- out_class  out  2  registered
- out_inst  out  INST_W  registered
- out_data  out  DATA_W  registered
- out_src  out  $clog2(N_REQ)  index of the granted requester
- out_ts  out  TS_W  timestamp of the accept cycle
- drop_cnt  out  DROP_W  saturating count of filtered records

## Operation
- Filtering: a request i is "filtered" when req_class[i]==NONE or class_en[req_class[i]]==0.
  - Filtered requests: req_ready[i]=1 in the same cycle, independent of arbitration and out_ready; the record is discarded.
- Eligible set E = valid and not filtered.
- Load condition: load_ok = !out_valid | out_ready.
- Arbitration: round-robin starting at pointer ptr, which searches upward from ptr modulo N_REQ for the first member of E.
  - When load_ok and E is nonempty, the winner w gets req_ready[w]=1, the output register loads w's record, and ptr becomes (w+1) mod N_REQ.
  - Non-winners in E keep req_ready=0.
- Output register: out_valid stays set until out_ready. Holding fields must not change while out_valid && !out_ready. Drain and load in the same cycle are allowed, giving full throughput.
- Timestamp: free-running TS_W counter ts, +1 every cycle, wraps from all-ones to 0. out_ts is loaded with the ts value of the accept cycle.
- drop_cnt: adds the popcount of filtered accepts per cycle and saturates at all-ones (never wraps).
- class_en changes take effect combinationally on the next evaluation. A record already in the output register is not recalled.
- Requesters must hold their fields stable while req_valid && !req_ready.

## Timing
- Reset values:
  - out_valid=0
  - out_class/out_inst/out_data/out_src/out_ts = 0
  - ptr=0
  - ts=0
  - drop_cnt=0
- During reset, req_ready=0 for all requesters.
- Latency: accept in cycle t gives out_valid in cycle t+1.
- Throughput: one record per cycle with out_ready held high.
- Reset asserted mid-operation discards the held record immediately (asynchronous clear). No partial handshake survives reset.
- Boundary cases:
  - When E is empty, ptr is unchanged.
  - Sink stalled with E nonempty: no eligible requester is accepted, but filtered requests are still accepted.
  - Simultaneous filtered and eligible requests on different requesters both complete in the same cycle.

## Test plan
- Reset, then class_en=4'b1110 and all 4 requesters valid with HOST_CHAN, out_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles; out_src matches; out_ts increments by 1 per record.
- out_ready=0 for 5 cycles while requester 2 is valid -> exactly one record accepted; out fields stable for all 5 cycles; req_ready[2]=0 after the first accept; release -> next record the cycle after out_ready rises.
- Requester 1 with class NONE and requester 3 with LOCAL_MEM while class_en[2]=0, held for 10 cycles -> req_ready=1 every cycle for both, out_valid never set, drop_cnt=20.
- Force drop_cnt to all-ones minus 1 (DROP_W=4 build: 14), then 2 filtered requests in one cycle -> drop_cnt=15 and stays 15 on further drops.
- Only requester 3 valid, then only requester 0 -> ptr wraps: grant 3, then 0 is granted the next cycle with ptr=1 afterward.
- Assert reset while out_valid=1 and ts=100 -> out_valid=0 and ts=0 immediately; no grant is issued until reset deasserts.

Source files
------------

// File: rtl/ofs_plat_log_record_arb.sv
// Log record arbiter: filters tagged monitor records by class enable, picks one
// eligible requester round-robin per cycle and registers it with a timestamp.
module ofs_plat_log_record_arb #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 64,
    parameter int INST_W = 4,
    parameter int TS_W   = 48,
    parameter int DROP_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3:0]                 class_en,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*2-1:0]         req_class,
    input  logic [N_REQ*INST_W-1:0]    req_inst,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_class,
    output logic [INST_W-1:0]          out_inst,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(N_REQ)-1:0]   out_src,
    output logic [TS_W-1:0]            out_ts,
    output logic [DROP_W-1:0]          drop_cnt
);

    localparam int SRC_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(N_REQ + 1);
    localparam logic [SRC_W:0]   N_EXT    = (SRC_W + 1)'(N_REQ);
    localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N_REQ - 1);

    logic [N_REQ-1:0]        filt_s;
    logic [N_REQ-1:0]        elig_s;
    logic [N_REQ-1:0]        grant_s;
    logic [CNT_W-1:0]        nfilt_s;
    logic [1:0]              cls_s;
    logic                    blocked_s;
    logic [SRC_W:0]          sum_s;
    logic [SRC_W-1:0]        idx_s;
    logic                    hit_s;
    logic                    found_s;
    logic [SRC_W-1:0]        win_s;
    logic                    load_ok_s;
    logic                    do_load_s;
    logic [1:0]              sel_class_s;
    logic [INST_W-1:0]       sel_inst_s;
    logic [DATA_W-1:0]       sel_data_s;
    logic [DROP_W+CNT_W-1:0] drop_sum_s;

    logic                    out_valid_q, out_valid_d;
    logic [1:0]              out_class_q, out_class_d;
    logic [INST_W-1:0]       out_inst_q,  out_inst_d;
    logic [DATA_W-1:0]       out_data_q,  out_data_d;
    logic [SRC_W-1:0]        out_src_q,   out_src_d;
    logic [TS_W-1:0]         out_ts_q,    out_ts_d;
    logic [SRC_W-1:0]        ptr_q,       ptr_d;
    logic [TS_W-1:0]         ts_q,        ts_d;
    logic [DROP_W-1:0]       drop_q,      drop_d;

    // Split valid requests into filtered (discarded) and eligible (arbitrated).
    always_comb begin
        filt_s    = '0;
        elig_s    = '0;
        nfilt_s   = '0;
        cls_s     = 2'd0;
        blocked_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cls_s     = req_class[2*i +: 2];
            // NONE is always blocked, so class_en[0] never matters
            blocked_s = (cls_s == 2'd0) || !class_en[cls_s];
            filt_s[i] = req_valid[i] && blocked_s;
            elig_s[i] = req_valid[i] && !blocked_s;
            nfilt_s   = nfilt_s + CNT_W'(filt_s[i]);
        end
    end

    // Round-robin search upward from ptr, modulo N_REQ.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        sum_s   = '0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            sum_s   = {1'b0, ptr_q} + (SRC_W + 1)'(k);
            idx_s   = (sum_s >= N_EXT) ? SRC_W'(sum_s - N_EXT) : sum_s[SRC_W-1:0];
            hit_s   = !found_s && elig_s[idx_s];
            win_s   = hit_s ? idx_s : win_s;
            found_s = found_s || hit_s;
        end
    end

    // Handshake: filtered requests always complete, the winner only when the register can load.
    always_comb begin
        load_ok_s = !out_valid_q || out_ready;
        do_load_s = load_ok_s && found_s && !reset;
        grant_s   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_s[i] = do_load_s && (win_s == SRC_W'(i));
        end
        req_ready = reset ? '0 : (filt_s | grant_s);
    end

    // Select the winning requester's record fields.
    always_comb begin
        sel_class_s = 2'd0;
        sel_inst_s  = '0;
        sel_data_s  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_class_s = sel_class_s | (req_class[2*i +: 2]           & {2{win_s == SRC_W'(i)}});
            sel_inst_s  = sel_inst_s  | (req_inst[i*INST_W +: INST_W]  & {INST_W{win_s == SRC_W'(i)}});
            sel_data_s  = sel_data_s  | (req_data[i*DATA_W +: DATA_W]  & {DATA_W{win_s == SRC_W'(i)}});
        end
    end

    // Next state for output register, pointer, timestamp and drop counter.
    always_comb begin
        out_valid_d = out_valid_q;
        out_class_d = out_class_q;
        out_inst_d  = out_inst_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_ts_d    = out_ts_q;
        ptr_d       = ptr_q;
        if (do_load_s) begin
            out_valid_d = 1'b1;
            out_class_d = sel_class_s;
            out_inst_d  = sel_inst_s;
            out_data_d  = sel_data_s;
            out_src_d   = win_s;
            out_ts_d    = ts_q;
            ptr_d       = (win_s == LAST_IDX) ? '0 : win_s + SRC_W'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        ts_d       = ts_q + TS_W'(1);
        // Add in a wider word so any carry out of DROP_W means saturate
        drop_sum_s = {{CNT_W{1'b0}}, drop_q} + {{DROP_W{1'b0}}, nfilt_s};
        drop_d     = (|drop_sum_s[DROP_W+CNT_W-1:DROP_W]) ? '1 : drop_sum_s[DROP_W-1:0];
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_class_q <= 2'd0;
            out_inst_q  <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_ts_q    <= '0;
            ptr_q       <= '0;
            ts_q        <= '0;
            drop_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_class_q <= out_class_d;
            out_inst_q  <= out_inst_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_ts_q    <= out_ts_d;
            ptr_q       <= ptr_d;
            ts_q        <= ts_d;
            drop_q      <= drop_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_inst  = out_inst_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_ts    = out_ts_q;
    assign drop_cnt  = drop_q;

endmodule
